// File: rtl/gf180mcu_fd_sc_mcu9t5v0__setn_seq_pkg.sv
// gf180mcu_fd_sc_mcu9t5v0__setn_seq_pkg: states, default sizing and counter-width helper for the SETN sequencer
package gf180mcu_fd_sc_mcu9t5v0__setn_seq_pkg;
  typedef enum logic [2:0] {S_SYNC, S_HOLD, S_RELEASE, S_RUN, S_SOFT} state_t;
  localparam int DEF_NGRP = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD = 8;
  localparam int DEF_GAP = 3;
  function automatic int cnt_width(input int hold, input int gap);
    return $clog2((hold > gap ? hold : gap) + 1);
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__setn_seq_sync.sv
// gf180mcu_fd_sc_mcu9t5v0__setn_seq_sync: asynchronously cleared reset-release synchronizer, outputs last stage
module gf180mcu_fd_sc_mcu9t5v0__setn_seq_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  output logic q
);
  logic [DEPTH-1:0] ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= '0;
    else ff <= {ff[DEPTH-2:0], 1'b1};
  assign q = ff[DEPTH-1];
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__setn_seq.sv
// gf180mcu_fd_sc_mcu9t5v0__setn_seq: staggered synchronous SETN release sequencer with async assert.
// Optional soft-set handshake enabled by GF180MCU_SETN_SEQ_SOFTSET_EN.
module gf180mcu_fd_sc_mcu9t5v0__setn_seq
  import gf180mcu_fd_sc_mcu9t5v0__setn_seq_pkg::*;
#(
  parameter int NGRP = DEF_NGRP,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD = DEF_HOLD,
  parameter int GAP = DEF_GAP
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            SOFT_REQ,
  output logic            SOFT_ACK,
  output logic [NGRP-1:0] SETN,
  output logic            DONE
);
  localparam int CW = cnt_width(HOLD, GAP);
  localparam int GW = NGRP > 1 ? $clog2(NGRP) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP - 1);
  localparam logic [GW-1:0] LAST = GW'(NGRP - 1);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [GW-1:0] grp, grp_d;
  logic [NGRP-1:0] setn_d;
  logic done_d, synced;
  gf180mcu_fd_sc_mcu9t5v0__setn_seq_sync #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk(CLK),
    .rst(RST),
    .q  (synced)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= S_SYNC;
      cnt <= '0;
      grp <= '0;
      SETN <= '0;
      DONE <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      grp <= grp_d;
      SETN <= setn_d;
      DONE <= done_d;
    end
`ifdef GF180MCU_SETN_SEQ_SOFTSET_EN
  logic ack, ack_d;
  always_ff @(posedge CLK or posedge RST)
    if (RST) ack <= 1'b0;
    else ack <= ack_d;
  assign SOFT_ACK = ack;
`else
  logic unused_soft_req;
  assign unused_soft_req = SOFT_REQ;
  assign SOFT_ACK = 1'b0;
`endif
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    grp_d = grp;
    setn_d = SETN;
    done_d = DONE;
`ifdef GF180MCU_SETN_SEQ_SOFTSET_EN
    ack_d = ack;
`endif
    case (state)
      S_SYNC: begin
        state_d = synced ? S_HOLD : S_SYNC;
        cnt_d = synced ? HOLD_LD : cnt;
      end
      // one counter times both the hold window and the inter-group gaps
      S_HOLD, S_RELEASE: begin
        cnt_d = cnt - 1'b1;
        if (cnt == '0) begin
          setn_d = SETN | (NGRP'(1) << grp);
          cnt_d = GAP_LD;
          grp_d = grp + 1'b1;
          done_d = grp == LAST;
          state_d = grp == LAST ? S_RUN : S_RELEASE;
        end
      end
`ifdef GF180MCU_SETN_SEQ_SOFTSET_EN
      S_RUN:
        if (SOFT_REQ) begin
          state_d = S_SOFT;
          setn_d = '0;
          done_d = 1'b0;
          ack_d = 1'b1;
          grp_d = '0;
        end
      S_SOFT:
        if (!SOFT_REQ) begin
          state_d = S_HOLD;
          ack_d = 1'b0;
          cnt_d = HOLD_LD;
        end
`else
      S_RUN: state_d = S_RUN;
`endif
      default: state_d = S_SYNC;
    endcase
  end
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__setn_seq.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__setn_seq: directed checks of release timing, async reset and soft-set handshake
module tb_gf180mcu_fd_sc_mcu9t5v0__setn_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic soft_req = 1'b0;
  logic soft_ack, done, soft_ack1, done1;
  logic [3:0] setn;
  logic [0:0] setn1;
  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__setn_seq dut (
    .CLK(clk), .RST(rst), .SOFT_REQ(soft_req), .SOFT_ACK(soft_ack), .SETN(setn), .DONE(done)
  );
  gf180mcu_fd_sc_mcu9t5v0__setn_seq #(.NGRP(1), .SYNC_STAGES(2), .HOLD(1), .GAP(3)) dut1 (
    .CLK(clk), .RST(rst), .SOFT_REQ(soft_req), .SOFT_ACK(soft_ack1), .SETN(setn1), .DONE(done1)
  );

  // bit i of SETN released once offset n reaches base + 3*i
  function automatic logic [3:0] exp_setn(input int n, input int base);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = n >= base + 3 * i;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int last);
    for (int n = 1; n <= last; n++) begin
      @(posedge clk);
      #1;
      vec++;
      if (setn !== exp_setn(n, 11) || done !== (n >= 20) || soft_ack !== 1'b0) begin
        err++;
        $display("FAIL %s edge %0d: setn=%b done=%b ack=%b, want setn=%b done=%b ack=0",
                 tag, n, setn, done, soft_ack, exp_setn(n, 11), n >= 20);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (setn !== 4'b0000 || done !== 1'b0 || soft_ack !== 1'b0) begin
      err++;
      $display("FAIL reset: setn=%b done=%b ack=%b, want 0000/0/0", setn, done, soft_ack);
    end
    rst = 1'b0;
  endtask

  task automatic test_release();
    check_seq("release", 22);
  endtask

  task automatic test_midseq_reset();
    do_reset();
    check_seq("pre_rst", 15);
    #2 rst = 1'b1;
    #1;
    vec++;
    if (setn !== 4'b0000 || done !== 1'b0) begin
      err++;
      $display("FAIL async_rst: setn=%b done=%b, want 0000/0", setn, done);
    end
    rst = 1'b0;
    check_seq("restart", 21);
  endtask

  task automatic test_ngrp1();
    do_reset();
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1;
      vec++;
      if (setn1 !== 1'(n >= 4) || done1 !== (n >= 4)) begin
        err++;
        $display("FAIL ngrp1 edge %0d: setn=%b done=%b, want %b/%b", n, setn1, done1, n >= 4, n >= 4);
      end
    end
  endtask

`ifdef GF180MCU_SETN_SEQ_SOFTSET_EN
  task automatic test_soft();
    do_reset();
    check_seq("soft_pre", 22);
    soft_req = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) soft_req = 1'b0;
      vec++;
      if (setn !== exp_setn(k, 12) || done !== (k >= 21) || soft_ack !== (k < 4)) begin
        err++;
        $display("FAIL soft e+%0d: setn=%b done=%b ack=%b, want %b/%b/%b",
                 k, setn, done, soft_ack, exp_setn(k, 12), k >= 21, k < 4);
      end
    end
  endtask

  task automatic test_soft_pending();
    do_reset();
    check_seq("pend_pre", 11);
    soft_req = 1'b1;
    for (int n = 12; n <= 22; n++) begin
      @(posedge clk);
      #1;
      if (n == 21) soft_req = 1'b0;
      vec++;
      if (n <= 20 && (soft_ack !== 1'b0 || setn !== exp_setn(n, 11) || done !== (n >= 20))) begin
        err++;
        $display("FAIL pending edge %0d: setn=%b done=%b ack=%b, want %b/%b/0",
                 n, setn, done, soft_ack, exp_setn(n, 11), n >= 20);
      end else if (n == 21 && (soft_ack !== 1'b1 || setn !== 4'b0000 || done !== 1'b0)) begin
        err++;
        $display("FAIL pending_ack edge 21: setn=%b done=%b ack=%b, want 0000/0/1", setn, done, soft_ack);
      end else if (n == 22 && soft_ack !== 1'b0) begin
        err++;
        $display("FAIL pending_drop edge 22: ack=%b, want 0", soft_ack);
      end
    end
  endtask
`else
  task automatic test_soft_ignored();
    do_reset();
    check_seq("ign_pre", 20);
    for (int k = 0; k < 8; k++) begin
      soft_req = k[0] ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      vec++;
      if (setn !== 4'b1111 || done !== 1'b1 || soft_ack !== 1'b0) begin
        err++;
        $display("FAIL soft_ignored k=%0d: setn=%b done=%b ack=%b, want 1111/1/0", k, setn, done, soft_ack);
      end
    end
    soft_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_release();
    test_midseq_reset();
    test_ngrp1();
`ifdef GF180MCU_SETN_SEQ_SOFTSET_EN
    test_soft();
    test_soft_pending();
`else
    test_soft_ignored();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__setn_seq.md
# gf180mcu_fd_sc_mcu9t5v0__setn_seq

Set-release sequencer that drives the active-low SETN pins of banks of dffsnq flops downstream. RST asserts all SETN outputs asynchronously and immediately. Release is synchronous and staggered: synchronize, hold, then release one group per GAP cycles, so the set-domain flops never see an asynchronous SETN de-assertion. An optional four-phase soft-set handshake re-runs the hold/release sequence without a hard reset.

## Interface
- NGRP, 4, number of independent SETN groups (≥1)
- SYNC_STAGES, 2, length of the RST de-assertion synchronizer (≥2)
- HOLD, 8, cycles SETN stays low after synchronized release (≥1)
- GAP, 3, cycles between successive group releases (≥1)

- CLK  input  1  rising-edge clock
- RST  input  1  reset; one clock, asynchronous active-high reset
- SOFT_REQ  input  1  soft-set request, four-phase, level
- SOFT_ACK  output  1  soft-set acknowledge
- SETN  output  NGRP  active-low set to downstream flop groups; bit 0 is released first
- DONE  output  1  high when all groups are released and the block is in RUN

## Operation
- States: SYNC, HOLD, RELEASE, RUN, SOFT.
- RST high (asynchronous):
  - SETN=0, DONE=0, SOFT_ACK=0.
  - Synchronizer cleared, counters cleared, state=SYNC.
  - Applies mid-sequence, from any state.
- SYNC: a constant 1 shifts through SYNC_STAGES flops. When the last stage is sampled at 1, the block goes to HOLD and loads the counter.
- HOLD: all SETN stay 0 for HOLD edges, then the block goes to RELEASE.
- RELEASE:
  - SETN[0] rises on the edge that leaves HOLD.
  - SETN[i] rises GAP edges after SETN[i-1].
  - Released bits stay 1.
  - DONE rises on the same edge as SETN[NGRP-1], and the state becomes RUN.
- RUN: SETN all 1, DONE=1.
- SOFT (macro only):
  - Entry: SOFT_REQ is sampled high in RUN. On that edge SETN goes all 0, DONE=0, SOFT_ACK=1.
  - The block stays in SOFT while SOFT_REQ is high.
  - Exit: SOFT_REQ is sampled low. On that edge SOFT_ACK=0, the counter is reloaded, and the state becomes HOLD. SYNC is skipped.
- SOFT_REQ high in SYNC/HOLD/RELEASE is held pending and is acknowledged on the first RUN cycle's edge.
- A single down-counter is shared by HOLD and GAP. Width is clog2(max(HOLD,GAP)+1). Saturating decrement is not needed; the counter is reloaded on every state/group step.
- A group index register of width clog2(NGRP), minimum 1, selects the next bit to release.

## Timing
- Edge n is the n-th rising CLK edge after RST falls. Defaults are in parentheses.
  - SETN[0] rises at edge SYNC_STAGES+1+HOLD (11).
  - SETN[i] rises at edge SYNC_STAGES+1+HOLD+i·GAP (14, 17, 20).
  - DONE rises at edge SYNC_STAGES+1+HOLD+(NGRP−1)·GAP (20).
- RST pulse narrower than one cycle: a full sequence is still required. The asynchronous clear must take effect.
- Soft set, with SOFT_REQ sampled high at edge e and low at edge f>e:
  - SOFT_ACK is 1 from e to f.
  - SETN[0] rises at f+HOLD.
  - DONE rises at f+HOLD+(NGRP−1)·GAP.
- NGRP=1: SETN[0] and DONE rise together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- GF180MCU_SETN_SEQ_SOFTSET_EN
  - Defined: SOFT state and handshake as above.
  - Undefined: SOFT_REQ is ignored, SOFT_ACK is tied 0, the SOFT state is absent, and RUN is terminal until RST.

## Structure
- Package gf180mcu_fd_sc_mcu9t5v0__setn_seq_pkg holds:
  - the state enum (SYNC, HOLD, RELEASE, RUN, SOFT);
  - the default constants for NGRP, SYNC_STAGES, HOLD and GAP;
  - a helper function for the counter width.
- Sub-module gf180mcu_fd_sc_mcu9t5v0__setn_seq_sync implements the asynchronously cleared SYNC_STAGES synchronizer. It has a parameter for depth and outputs the last stage.

## Test plan
- Defaults, RST high 3 cycles then low: SETN=4'b0000 through edge 10; 0001@11, 0011@14, 0111@17, 1111@20; DONE=1@20.
- RST re-asserted between edges 15 and 16: SETN=0000 and DONE=0 immediately, without a clock edge. After RST falls, the full sequence restarts from edge 1.
- Macro on, in RUN, SOFT_REQ high at edge e and low at e+4:
  - SETN=0000, SOFT_ACK=1, DONE=0 at e.
  - SOFT_ACK=0 at e+4.
  - SETN=0001 at e+12.
  - DONE=1 at e+21.
- Macro on, SOFT_REQ raised at edge 12, during RELEASE: SOFT_ACK stays 0 until RUN. At edge 21, SOFT_ACK=1 and SETN=0000.
- Macro off: SOFT_REQ toggling in RUN leaves SETN=1111, DONE=1, SOFT_ACK=0.
- NGRP=1, HOLD=1, SYNC_STAGES=2: SETN[0] and DONE both rise at edge 4.
